// File: rtl/eth_mac_pkg.sv
// Shared types and constants for the MAC transmit access path: FSM states,
// default timing constants and the backoff LFSR definition.
package eth_mac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TX      = 2'd1,
    JAM     = 2'd2,
    BACKOFF = 2'd3
  } tx_state_e;

  localparam int IFG_NIB_DEF       = 24;
  localparam int SLOT_NIB_DEF      = 128;
  localparam int JAM_NIB_DEF       = 8;
  localparam int MAX_ATTEMPTS_DEF  = 16;
  localparam int BACKOFF_LIMIT_DEF = 10;

  // x^10 + x^7 + 1: feedback from bits 9 and 6.
  localparam logic [9:0] LFSR_SEED = 10'h3FF;
  localparam logic [9:0] LFSR_TAPS = 10'h240;

  function automatic logic [9:0] lfsr_next(input logic [9:0] cur);
    return {cur[8:0], ^(cur & LFSR_TAPS)};
  endfunction

  // Mask of (2^min(attempt,limit))-1; an exponent of 10 or more gives all ones.
  function automatic logic [9:0] backoff_mask(input logic [4:0] attempt,
                                              input logic [4:0] limit);
    logic [4:0]  exp_s;
    logic [10:0] mask_s;
    exp_s  = (attempt > limit) ? limit : attempt;
    mask_s = (11'd1 << exp_s) - 11'd1;
    return mask_s[9:0];
  endfunction

endpackage

// File: rtl/eth_backoff_lfsr.sv
// Free-running 10-bit Fibonacci LFSR; the caller supplies a mask and gets the
// masked value back, so the same block serves backoff and test-pattern use.
module eth_backoff_lfsr
  import eth_mac_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] mask,
  output logic [9:0] masked
);

  logic [9:0] value_r;

  // Advance the sequence every cycle; the seed is nonzero so it never locks up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= LFSR_SEED;
    end else begin
      value_r <= lfsr_next(value_r);
    end
  end

  assign masked = value_r & mask;

endmodule

// File: rtl/eth_tx_csma_ctrl.sv
// CSMA/CD transmit access controller: IFG and carrier deferral, collision
// detection, jam, truncated binary exponential backoff and frame status.
module eth_tx_csma_ctrl
  import eth_mac_pkg::*;
#(
  parameter int IFG_NIB       = IFG_NIB_DEF,
  parameter int SLOT_NIB      = SLOT_NIB_DEF,
  parameter int JAM_NIB       = JAM_NIB_DEF,
  parameter int MAX_ATTEMPTS  = MAX_ATTEMPTS_DEF,
  parameter int BACKOFF_LIMIT = BACKOFF_LIMIT_DEF
) (
  input  logic       mtx_clk_pad_i,
  input  logic       rst_n,
  input  logic       full_duplex_i,
  input  logic       tx_req_i,
  input  logic       tx_done_i,
  input  logic       mcrs_pad_i,
  input  logic       mcoll_pad_i,
  output logic       tx_go_o,
  output logic       jam_o,
  output logic       defer_o,
  output logic       tx_ok_o,
  output logic       tx_fail_o,
  output logic       late_coll_o,
  output logic [4:0] retry_cnt_o
);

  localparam int IFG_W = $clog2(IFG_NIB + 1);
  localparam int NIB_W = $clog2(SLOT_NIB + 1);
  localparam int JAM_W = $clog2(JAM_NIB + 1);

  logic             crs_meta_r, crs_sync_r;
  logic             coll_meta_r, coll_sync_r;
  logic [IFG_W-1:0] ifg_cnt_r;
  tx_state_e        state_r;
  logic [NIB_W-1:0] nib_cnt_r;
  logic [NIB_W-1:0] bo_nib_r;
  logic [JAM_W-1:0] jam_cnt_r;
  logic [9:0]       slot_cnt_r;
  logic [4:0]       attempt_r;
  logic             late_r;
  logic             status_seen_r;

  logic             ifg_ok_s;
  logic             crs_hd_s;
  logic             coll_hd_s;
  logic [9:0]       mask_s;
  logic [9:0]       masked_s;

  assign ifg_ok_s  = (ifg_cnt_r == IFG_W'(IFG_NIB));
  assign crs_hd_s  = crs_sync_r & ~full_duplex_i;
  assign coll_hd_s = coll_sync_r & ~full_duplex_i;
  assign mask_s    = backoff_mask(attempt_r, 5'(BACKOFF_LIMIT));

  eth_backoff_lfsr u_lfsr (
    .clk    (mtx_clk_pad_i),
    .rst_n  (rst_n),
    .mask   (mask_s),
    .masked (masked_s)
  );

  // Two-flop synchronizers for the asynchronous PHY carrier and collision pins.
  always_ff @(posedge mtx_clk_pad_i or negedge rst_n) begin
    if (!rst_n) begin
      crs_meta_r  <= 1'b0;
      crs_sync_r  <= 1'b0;
      coll_meta_r <= 1'b0;
      coll_sync_r <= 1'b0;
    end else begin
      crs_meta_r  <= mcrs_pad_i;
      crs_sync_r  <= crs_meta_r;
      coll_meta_r <= mcoll_pad_i;
      coll_sync_r <= coll_meta_r;
    end
  end

  // Inter-frame gap timer: restarts on own transmission/jam or on carrier.
  always_ff @(posedge mtx_clk_pad_i or negedge rst_n) begin
    if (!rst_n) begin
      ifg_cnt_r <= '0;
    end else if ((state_r == TX) || (state_r == JAM) || crs_hd_s) begin
      ifg_cnt_r <= '0;
    end else if (!ifg_ok_s) begin
      ifg_cnt_r <= ifg_cnt_r + IFG_W'(1);
    end else begin
      ifg_cnt_r <= ifg_cnt_r;
    end
  end

  // Access FSM with registered outputs; status and go pulses last one cycle.
  always_ff @(posedge mtx_clk_pad_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      nib_cnt_r     <= '0;
      bo_nib_r      <= '0;
      jam_cnt_r     <= '0;
      slot_cnt_r    <= 10'd0;
      attempt_r     <= 5'd0;
      late_r        <= 1'b0;
      status_seen_r <= 1'b0;
      tx_go_o       <= 1'b0;
      jam_o         <= 1'b0;
      defer_o       <= 1'b0;
      tx_ok_o       <= 1'b0;
      tx_fail_o     <= 1'b0;
      late_coll_o   <= 1'b0;
      retry_cnt_o   <= 5'd0;
    end else begin
      tx_go_o     <= 1'b0;
      defer_o     <= 1'b0;
      tx_ok_o     <= 1'b0;
      tx_fail_o   <= 1'b0;
      late_coll_o <= 1'b0;
      case (state_r)
        IDLE: begin
          jam_o <= 1'b0;
          if (tx_req_i && ifg_ok_s) begin
            tx_go_o   <= 1'b1;
            nib_cnt_r <= '0;
            late_r    <= 1'b0;
            state_r   <= TX;
            if (status_seen_r) begin
              retry_cnt_o   <= 5'd0;
              status_seen_r <= 1'b0;
            end
          end else if (tx_req_i) begin
            defer_o <= 1'b1;
          end
        end
        TX: begin
          if (nib_cnt_r != NIB_W'(SLOT_NIB)) begin
            nib_cnt_r <= nib_cnt_r + NIB_W'(1);
          end
          // A collision on the last nibble still aborts the frame.
          if (coll_hd_s) begin
            attempt_r   <= attempt_r + 5'd1;
            retry_cnt_o <= attempt_r + 5'd1;
            jam_cnt_r   <= '0;
            jam_o       <= 1'b1;
            late_r      <= (nib_cnt_r >= NIB_W'(SLOT_NIB));
            state_r     <= JAM;
          end else if (tx_done_i) begin
            tx_ok_o       <= 1'b1;
            attempt_r     <= 5'd0;
            status_seen_r <= 1'b1;
            state_r       <= IDLE;
          end
        end
        JAM: begin
          if (jam_cnt_r == JAM_W'(JAM_NIB - 1)) begin
            jam_o <= 1'b0;
            if (late_r) begin
              tx_fail_o     <= 1'b1;
              late_coll_o   <= 1'b1;
              attempt_r     <= 5'd0;
              status_seen_r <= 1'b1;
              state_r       <= IDLE;
            end else if (attempt_r == 5'(MAX_ATTEMPTS)) begin
              tx_fail_o     <= 1'b1;
              attempt_r     <= 5'd0;
              status_seen_r <= 1'b1;
              state_r       <= IDLE;
            end else if (masked_s == 10'd0) begin
              state_r <= IDLE;
            end else begin
              slot_cnt_r <= masked_s;
              bo_nib_r   <= '0;
              state_r    <= BACKOFF;
            end
          end else begin
            jam_cnt_r <= jam_cnt_r + JAM_W'(1);
          end
        end
        BACKOFF: begin
          if (bo_nib_r == NIB_W'(SLOT_NIB - 1)) begin
            bo_nib_r <= '0;
            if (slot_cnt_r == 10'd1) begin
              state_r <= IDLE;
            end else begin
              slot_cnt_r <= slot_cnt_r - 10'd1;
            end
          end else begin
            bo_nib_r <= bo_nib_r + NIB_W'(1);
          end
        end
        default: begin
          jam_o   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
